// File: rtl/alu_cond_unit.sv
// Result buffer for ALU words and their flags, with condition-code evaluation on the head entry.
// Also keeps sticky indicators for overflow and for inconsistent SF/ZF flags on accepted words.
module alu_cond_unit #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_c,
    input  logic                     in_of,
    input  logic                     in_cf,
    input  logic                     in_sf,
    input  logic                     in_zf,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic [3:0]               cond,
    output logic [31:0]              out_c,
    output logic [3:0]               out_flags,
    output logic                     out_taken,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     of_seen,
    output logic                     flag_err,
    input  logic                     clr_sticky
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [31:0]   r_data  [DEPTH];
    logic [3:0]    r_flags [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_of_seen;
    logic          r_flag_err;

    logic          w_in_ready;
    logic          w_out_valid;
    logic          w_push;
    logic          w_pop;
    logic          w_in_bad;
    logic [31:0]   w_head_c;
    logic [3:0]    w_head_f;
    logic          w_taken;
    logic          w_n;
    logic          w_z;
    logic          w_c;
    logic          w_v;

    // Readiness depends only on occupancy so the producer never sees a comb loop.
    assign w_in_ready  = (r_count != FULL_CNT);
    assign w_out_valid = (r_count != '0);
    assign w_push      = in_valid && w_in_ready;
    assign w_pop       = w_out_valid && out_ready;

    assign w_in_bad = (in_zf != (in_c == 32'd0)) || (in_sf != in_c[31]);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data[r_wr_ptr]  <= in_c;
            r_flags[r_wr_ptr] <= {in_of, in_cf, in_sf, in_zf};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A new event in the same cycle as a clear takes priority so it is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_of_seen  <= 1'b0;
            r_flag_err <= 1'b0;
        end else begin
            if (w_push && in_of) begin
                r_of_seen <= 1'b1;
            end else if (clr_sticky) begin
                r_of_seen <= 1'b0;
            end
            if (w_push && w_in_bad) begin
                r_flag_err <= 1'b1;
            end else if (clr_sticky) begin
                r_flag_err <= 1'b0;
            end
        end
    end

    assign w_head_c = w_out_valid ? r_data[r_rd_ptr]  : 32'd0;
    assign w_head_f = w_out_valid ? r_flags[r_rd_ptr] : 4'd0;

    assign w_v = w_head_f[3];
    assign w_c = w_head_f[2];
    assign w_n = w_head_f[1];
    assign w_z = w_head_f[0];

    always_comb begin
        w_taken = 1'b0;
        case (cond)
            4'h0: w_taken = w_z;
            4'h1: w_taken = !w_z;
            4'h2: w_taken = w_c;
            4'h3: w_taken = !w_c;
            4'h4: w_taken = w_n;
            4'h5: w_taken = !w_n;
            4'h6: w_taken = w_v;
            4'h7: w_taken = !w_v;
            4'h8: w_taken = w_c && !w_z;
            4'h9: w_taken = !w_c || w_z;
            4'hA: w_taken = (w_n == w_v);
            4'hB: w_taken = (w_n != w_v);
            4'hC: w_taken = !w_z && (w_n == w_v);
            4'hD: w_taken = w_z || (w_n != w_v);
            4'hE: w_taken = 1'b1;
            default: w_taken = 1'b0;
        endcase
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_c     = w_head_c;
    assign out_flags = w_head_f;
    assign out_taken = w_out_valid && w_taken;
    assign count     = r_count;
    assign of_seen   = r_of_seen;
    assign flag_err  = r_flag_err;

endmodule
